// File: rtl/vpu_sram_rd_responder_pkg.sv
// VPU SRAM read-port shared constants and request bundle.
// Bank geometry and macro read latency.
package vpu_sram_rd_responder_pkg;

  localparam int SRAM_BANK_CNT       = 4;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 8;
  localparam int SRAM_DATA_WIDTH     = 16;
  localparam int SRAM_RD_LATENCY     = 1;

  typedef struct packed {
    logic [SRAM_BANK_CNT_LG2-1:0]   rid;
    logic [SRAM_BANK_DEPTH_LG2-1:0] addr;
    logic                           reb;
    logic                           rlast;
  } sram_rd_req_t;

endpackage

// File: rtl/vpu_sram_rd_responder_if.sv
// Source-port side of the SRAM read protocol.
// Hosts drive requests, the responder drives ack/data.
interface vpu_sram_rd_responder_if
  import vpu_sram_rd_responder_pkg::*;
#(
  parameter int N_PORTS = 3
);

  localparam int BL = SRAM_BANK_CNT_LG2;
  localparam int AL = SRAM_BANK_DEPTH_LG2;
  localparam int DW = SRAM_DATA_WIDTH;

  logic [N_PORTS-1:0]    src_req_i;
  logic [N_PORTS*BL-1:0] src_rid_i;
  logic [N_PORTS*AL-1:0] src_addr_i;
  logic [N_PORTS-1:0]    src_reb_i;
  logic [N_PORTS-1:0]    src_rlast_i;
  logic [N_PORTS-1:0]    src_ack_o;
  logic [N_PORTS*DW-1:0] src_rdata_o;
  logic [N_PORTS-1:0]    src_rvalid_o;

  modport master (
    output src_req_i, src_rid_i, src_addr_i,
    output src_reb_i, src_rlast_i,
    input  src_ack_o, src_rdata_o, src_rvalid_o
  );

  modport slave (
    input  src_req_i, src_rid_i, src_addr_i,
    input  src_reb_i, src_rlast_i,
    output src_ack_o, src_rdata_o, src_rvalid_o
  );

endinterface

// File: rtl/vpu_rr_arbiter.sv
// Round-robin arbiter, one-hot grant.
// Search starts one past the last winner.
module vpu_rr_arbiter #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         upd_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;
  logic [W-1:0] k;
  logic         found;

  // pick the first requester after ptr_q
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = W'((int'(ptr_q) + i) % N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        ptr_d    = k;
      end
    end
  end

  // remember the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= W'(N - 1);
    end else if (upd_i && found) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/vpu_sram_rd_responder.sv
// Per-bank arbitration of single-beat SRAM reads
// with fixed-latency data return to each port.
module vpu_sram_rd_responder
  import vpu_sram_rd_responder_pkg::*;
#(
  parameter int N_PORTS      = 3,
  parameter int BANK_CNT     = SRAM_BANK_CNT,
  parameter int BANK_CNT_LG2 = SRAM_BANK_CNT_LG2,
  parameter int DEPTH_LG2    = SRAM_BANK_DEPTH_LG2,
  parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
  parameter int RD_LATENCY   = SRAM_RD_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  vpu_sram_rd_responder_if.slave src,
  output logic [BANK_CNT-1:0]            bank_reb_o,
  output logic [BANK_CNT*DEPTH_LG2-1:0]  bank_addr_o,
  input  logic [BANK_CNT*DATA_WIDTH-1:0] bank_rdata_i,
  output logic                           proto_err_o
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int BL = BANK_CNT_LG2;
  localparam int AL = DEPTH_LG2;
  localparam int DW = DATA_WIDTH;

  sram_rd_req_t         rq [N_PORTS];
  logic [N_PORTS-1:0]   elig;
  logic [N_PORTS-1:0]   bad;
  logic [N_PORTS-1:0]   breq [BANK_CNT];
  logic [N_PORTS-1:0]   gnt  [BANK_CNT];
  logic [PW-1:0]        ptr  [BANK_CNT];
  logic [AL-1:0]        gaddr [BANK_CNT];
  logic [N_PORTS-1:0]   ack;
  logic [N_PORTS-1:0]   rvalid;
  logic [N_PORTS*DW-1:0] rdata;

  logic [N_PORTS-1:0]    out_q;
  logic [BANK_CNT-1:0]   reb_q;
  logic [BANK_CNT*AL-1:0] addr_q;
  logic [RD_LATENCY-1:0] pv_q  [BANK_CNT];
  logic [PW-1:0]         pid_q [BANK_CNT][RD_LATENCY];
  logic                  err_q;

  // unpack requests, classify eligible / malformed
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      rq[p].rid   = src.src_rid_i[p*BL +: BL];
      rq[p].addr  = src.src_addr_i[p*AL +: AL];
      rq[p].reb   = src.src_reb_i[p];
      rq[p].rlast = src.src_rlast_i[p];
      bad[p]  = src.src_req_i[p]
              & (rq[p].reb | ~rq[p].rlast
                 | (int'(rq[p].rid) >= BANK_CNT));
      elig[p] = rst_n & src.src_req_i[p]
              & ~rq[p].reb & ~out_q[p]
              & (int'(rq[p].rid) < BANK_CNT);
    end
  end

  // per-bank request vectors, acks and winning address
  always_comb begin
    ack = '0;
    for (int b = 0; b < BANK_CNT; b++) begin
      gaddr[b] = '0;
      for (int p = 0; p < N_PORTS; p++) begin
        breq[b][p] = elig[p] && (int'(rq[p].rid) == b);
        ack[p]     = ack[p] | gnt[b][p];
        if (gnt[b][p]) gaddr[b] = gaddr[b] | rq[p].addr;
      end
    end
  end

  for (genvar b = 0; b < BANK_CNT; b++) begin : g_arb
    vpu_rr_arbiter #(
      .N (N_PORTS),
      .W (PW)
    ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (breq[b]),
      .upd_i (1'b1),
      .gnt_o (gnt[b]),
      .ptr_o (ptr[b])
    );
  end

  // route each bank's pipeline tail to its port
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int b = 0; b < BANK_CNT; b++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (pv_q[b][RD_LATENCY-1]
            && int'(pid_q[b][RD_LATENCY-1]) == p) begin
          rvalid[p] = 1'b1;
          rdata[p*DW +: DW] = bank_rdata_i[b*DW +: DW];
        end
      end
    end
  end

  // bank command, outstanding, return pipe and error state;
  // stage 0 of the return pipe is reb_q with ptr (the winner)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      reb_q  <= '1;
      addr_q <= '0;
      err_q  <= 1'b0;
      for (int b = 0; b < BANK_CNT; b++) begin
        pv_q[b] <= '0;
        for (int s = 0; s < RD_LATENCY; s++) begin
          pid_q[b][s] <= '0;
        end
      end
    end else begin
      out_q <= (out_q | ack) & ~rvalid;
      err_q <= err_q | (|bad);
      for (int b = 0; b < BANK_CNT; b++) begin
        reb_q[b] <= ~(|gnt[b]);
        if (|gnt[b]) addr_q[b*AL +: AL] <= gaddr[b];
        pv_q[b][0]  <= ~reb_q[b];
        pid_q[b][0] <= ptr[b];
        for (int s = 1; s < RD_LATENCY; s++) begin
          pv_q[b][s]  <= pv_q[b][s-1];
          pid_q[b][s] <= pid_q[b][s-1];
        end
      end
    end
  end

  assign src.src_ack_o    = ack;
  assign src.src_rvalid_o = rvalid;
  assign src.src_rdata_o  = rdata;
  assign bank_reb_o       = reb_q;
  assign bank_addr_o      = addr_q;
  assign proto_err_o      = err_q;

endmodule

// File: tb/tb_vpu_sram_rd_responder.sv
// Bench for vpu_sram_rd_responder: cycle model
// with return queue plus directed literal checks.
module tb_vpu_sram_rd_responder;
  import vpu_sram_rd_responder_pkg::*;

  localparam int NP  = 3;
  localparam int NB  = SRAM_BANK_CNT;
  localparam int AL  = SRAM_BANK_DEPTH_LG2;
  localparam int DW  = SRAM_DATA_WIDTH;
  localparam int LAT = SRAM_RD_LATENCY;

  logic clk;
  logic rst_n;
  logic [NB-1:0]    bank_reb;
  logic [NB*AL-1:0] bank_addr;
  logic [NB*DW-1:0] bank_rdata;
  logic             perr;

  int errors;
  int checks;

  vpu_sram_rd_responder_if #(.N_PORTS(NP)) sif ();

  vpu_sram_rd_responder #(.N_PORTS(NP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src          (sif.slave),
    .bank_reb_o   (bank_reb),
    .bank_addr_o  (bank_addr),
    .bank_rdata_i (bank_rdata),
    .proto_err_o  (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] ev);
    checks++;
    if (act !== ev) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, ev);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit rq,
                          input int rid,
                          input logic [7:0] a,
                          input bit rb, input bit rl);
    sif.src_req_i[p]          = rq;
    sif.src_rid_i[p*2 +: 2]   = 2'(rid);
    sif.src_addr_i[p*AL +: AL] = a;
    sif.src_reb_i[p]          = rb;
    sif.src_rlast_i[p]        = rl;
  endtask

  task automatic set_bank(input int b,
                          input logic [15:0] d);
    bank_rdata[b*DW +: DW] = d;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int p;
    int b;
    int due;
  } ret_t;

  ret_t       pend[$];
  int         cyc_n;
  bit         mout [NP];
  int         mptr [NB];
  bit         merr;
  bit         creb [NB];
  logic [7:0] caddr [NB];
  int         gp [NB];

  always @(negedge clk) begin
    logic [NP-1:0]    eack;
    logic [NP-1:0]    evld;
    logic [NP*DW-1:0] edat;
    int pp;
    eack = '0;
    evld = '0;
    edat = '0;
    cyc_n++;
    if (!rst_n) begin
      chk("rst_ack", sif.src_ack_o, 0);
      chk("rst_rvalid", sif.src_rvalid_o, 0);
      chk("rst_rdata", sif.src_rdata_o, 0);
      chk("rst_reb", bank_reb, {NB{1'b1}});
      chk("rst_addr", bank_addr, 0);
      chk("rst_perr", perr, 0);
      pend.delete();
      merr = 0;
      for (int p = 0; p < NP; p++) mout[p] = 0;
      for (int b = 0; b < NB; b++) begin
        mptr[b] = NP - 1;
        creb[b] = 1;
        caddr[b] = '0;
      end
    end else begin
      foreach (pend[i]) begin
        if (pend[i].due == cyc_n) begin
          evld[pend[i].p] = 1'b1;
          edat[pend[i].p*DW +: DW] =
            bank_rdata[pend[i].b*DW +: DW];
        end
      end
      for (int b = 0; b < NB; b++) begin
        gp[b] = -1;
        for (int o = 1; o <= NP; o++) begin
          pp = (mptr[b] + o) % NP;
          if (gp[b] < 0 && sif.src_req_i[pp]
              && !sif.src_reb_i[pp]
              && int'(sif.src_rid_i[pp*2 +: 2]) == b
              && !mout[pp])
            gp[b] = pp;
        end
        if (gp[b] >= 0) eack[gp[b]] = 1'b1;
      end
      chk("ack", sif.src_ack_o, eack);
      chk("rvalid", sif.src_rvalid_o, evld);
      chk("rdata", sif.src_rdata_o, edat);
      chk("perr", perr, merr);
      for (int b = 0; b < NB; b++) begin
        chk("bank_reb", bank_reb[b], creb[b]);
        if (!creb[b])
          chk("bank_addr", bank_addr[b*AL +: AL],
              caddr[b]);
      end
      for (int p = 0; p < NP; p++)
        if (evld[p]) mout[p] = 0;
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due == cyc_n) pend.delete(i);
      for (int b = 0; b < NB; b++) begin
        creb[b] = 1;
        if (gp[b] >= 0) begin
          creb[b]  = 0;
          caddr[b] = sif.src_addr_i[gp[b]*AL +: AL];
          mout[gp[b]] = 1;
          mptr[b] = gp[b];
          pend.push_back('{gp[b], b, cyc_n + 1 + LAT});
        end
      end
      for (int p = 0; p < NP; p++)
        if (sif.src_req_i[p]
            && (sif.src_reb_i[p] || !sif.src_rlast_i[p]))
          merr = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [NP-1:0] ord [4];

  initial begin
    errors = 0;
    checks = 0;
    cyc_n  = 0;
    rst_n  = 1'b0;
    bank_rdata = '0;
    for (int p = 0; p < NP; p++) set_port(p, 0, 0, 0, 0, 1);
    ord[0] = 3'b001;
    ord[1] = 3'b010;
    ord[2] = 3'b100;
    ord[3] = 3'b001;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // single read: port 0 -> bank 1
    set_bank(1, 16'hA5A5);
    set_port(0, 1, 1, 8'h10, 0, 1);
    @(negedge clk);
    chk("t1_ack0", sif.src_ack_o[0], 1'b1);
    cyc();
    set_port(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t1_reb1", bank_reb[1], 1'b0);
    chk("t1_addr1", bank_addr[1*AL +: AL], 8'h10);
    cyc();
    @(negedge clk);
    chk("t1_rvalid0", sif.src_rvalid_o[0], 1'b1);
    chk("t1_rdata0", sif.src_rdata_o[DW-1:0], 16'hA5A5);
    repeat (3) cyc();

    // three ports held on bank 0 after reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_bank(0, 16'h1234);
    set_port(0, 1, 0, 8'h20, 0, 1);
    set_port(1, 1, 0, 8'h21, 0, 1);
    set_port(2, 1, 0, 8'h22, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_order", sif.src_ack_o, ord[i]);
      cyc();
    end
    for (int p = 0; p < NP; p++) set_port(p, 0, 0, 0, 0, 1);
    repeat (4) cyc();

    // two banks in parallel
    set_bank(0, 16'h1111);
    set_bank(2, 16'h2222);
    set_port(0, 1, 0, 8'h30, 0, 1);
    set_port(1, 1, 2, 8'h31, 0, 1);
    @(negedge clk);
    chk("t3_ack", sif.src_ack_o, 3'b011);
    cyc();
    set_port(0, 0, 0, 0, 0, 1);
    set_port(1, 0, 0, 0, 0, 1);
    cyc();
    @(negedge clk);
    chk("t3_rvalid", sif.src_rvalid_o, 3'b011);
    chk("t3_rdata0", sif.src_rdata_o[DW-1:0], 16'h1111);
    chk("t3_rdata1", sif.src_rdata_o[2*DW-1:DW], 16'h2222);
    repeat (3) cyc();

    // reb=1 ignored, rlast=0 still served
    set_bank(3, 16'h3C3C);
    set_port(1, 1, 3, 8'h55, 0, 0);
    set_port(2, 1, 3, 8'h66, 1, 1);
    @(negedge clk);
    chk("t4_ack", sif.src_ack_o, 3'b010);
    chk("t4_perr_pre", perr, 1'b0);
    cyc();
    set_port(1, 0, 0, 0, 0, 1);
    set_port(2, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t4_reb", bank_reb, 4'b0111);
    chk("t4_perr", perr, 1'b1);
    repeat (3) cyc();
    @(negedge clk);
    chk("t4_perr_held", perr, 1'b1);
    cyc();

    // reset while a read is in flight
    set_port(0, 1, 1, 8'h40, 0, 1);
    @(negedge clk);
    chk("t5_ack", sif.src_ack_o[0], 1'b1);
    cyc();
    set_port(0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_reb", bank_reb, 4'b1111);
    chk("t5_rst_perr", perr, 1'b0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_rvalid", sif.src_rvalid_o, 3'b000);
    cyc();
    set_bank(1, 16'h7E7E);
    set_port(0, 1, 1, 8'h41, 0, 1);
    @(negedge clk);
    chk("t5_ack2", sif.src_ack_o[0], 1'b1);
    cyc();
    set_port(0, 0, 0, 0, 0, 1);
    cyc();
    @(negedge clk);
    chk("t5_rdata", sif.src_rdata_o[DW-1:0], 16'h7E7E);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/vpu_sram_rd_responder.md
Name: vpu_sram_rd_responder

Overview:
- Device (responder) end of the VPU SRAM read-port protocol (req/ack, rid, addr, reb, rlast, rdata, rvalid).
- Source-port controllers are the hosts. This block arbitrates their single-beat read requests per SRAM bank and drives the bank macros.
- It routes each bank's read data back to the requesting port, with an rvalid pulse at a fixed latency.
- Sits in the SRAM interconnect between the operand-fetch source ports and the SRAM banks.

Parameters:
- N_PORTS, 3, number of source (host) ports.
- BANK_CNT, VPU_PKG::SRAM_BANK_CNT, number of SRAM banks.
- BANK_CNT_LG2, VPU_PKG::SRAM_BANK_CNT_LG2, width of rid.
- DEPTH_LG2, VPU_PKG::SRAM_BANK_DEPTH_LG2, bank address width.
- DATA_WIDTH, VPU_PKG::SRAM_DATA_WIDTH, read data width.
- RD_LATENCY, 1, bank macro cycles from registered command to valid rdata (must be at least 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_req_i  in  N_PORTS  per-port request, held until ack
- src_rid_i  in  N_PORTS*BANK_CNT_LG2  target bank per port
- src_addr_i  in  N_PORTS*DEPTH_LG2  bank row per port
- src_reb_i  in  N_PORTS  read enable bar, must be 0 with req
- src_rlast_i  in  N_PORTS  last beat, must be 1 (single-beat protocol)
- src_ack_o  out  N_PORTS  grant, combinational, same cycle as req
- src_rdata_o  out  N_PORTS*DATA_WIDTH  read data per port
- src_rvalid_o  out  N_PORTS  one-cycle data-valid pulse per port
- bank_reb_o  out  BANK_CNT  bank read enable bar, registered
- bank_addr_o  out  BANK_CNT*DEPTH_LG2  bank address, registered
- bank_rdata_i  in  BANK_CNT*DATA_WIDTH  bank read data
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n low), all outputs and state forced immediately:
  - src_ack_o=0, src_rvalid_o=0, src_rdata_o=0.
  - bank_reb_o all 1, bank_addr_o=0, proto_err_o=0.
  - Outstanding flags cleared, return pipelines flushed, RR pointers = N_PORTS-1.
- Eligibility: port p is eligible when src_req_i[p]=1 and outstanding[p]=0.
- Arbitration: each bank b arbitrates independently, round-robin, among eligible ports whose rid equals b.
  - Search starts at ptr[b]+1, mod N_PORTS.
  - At most one grant per bank per cycle. Different banks may grant in the same cycle.
- Grant cycle T:
  - src_ack_o[p]=1 combinationally.
  - outstanding[p] is set at T+1.
  - ptr[b] is set to p at T+1.
  - bank_reb_o[b]=0 and bank_addr_o[b]=addr are registered, visible T+1 for exactly one cycle, then reb returns to 1.
- Return path: per-bank shift register of (valid, port id), depth 1+RD_LATENCY.
  - Bank rdata is sampled at T+1+RD_LATENCY.
  - src_rvalid_o[p]=1 and src_rdata_o[p]=bank_rdata_i[b] at T+1+RD_LATENCY, combinational from the pipeline tail.
  - Default RD_LATENCY=1 gives rvalid at T+2.
  - outstanding[p] clears the same cycle rvalid is asserted.
- src_rdata_o[p] is 0 whenever src_rvalid_o[p]=0.
- No collisions: one outstanding per port means at most one bank returns to a given port per cycle.
- Re-request while outstanding: no ack; req is held; the port is granted only after its rvalid, earliest the cycle after.
- Protocol errors: req=1 with reb=1 or rlast=0 sets proto_err_o, sticky until reset.
  - reb=1: request ignored, no ack.
  - rlast=0: request still served.
- rid ≥ BANK_CNT with req=1: proto_err_o set, no ack.
- Back-to-back throughput: one read per bank per cycle.
- Reset mid-flight: in-flight reads are discarded, no rvalid after reset release. Hosts must restart.

Decomposition:
- In VPU_PKG:
  - SRAM_BANK_CNT, SRAM_BANK_CNT_LG2, SRAM_BANK_DEPTH_LG2, SRAM_DATA_WIDTH.
  - New SRAM_RD_LATENCY constant.
  - Typedef sram_rd_req_t {rid, addr, reb, rlast}.
- One sub-module, vpu_rr_arbiter:
  - Parameter N.
  - Inputs: req vector, update enable. Outputs: one-hot grant, internal pointer.
  - Instantiated BANK_CNT times.

Test Plan:
- Port 0, rid=1, addr=0x10 at T; bank1 returns 0xA5A5 at T+2 -> ack[0] at T; bank_reb_o[1]=0 and bank_addr_o[1]=0x10 at T+1; rvalid[0] with rdata 0xA5A5 at T+2.
- Ports 0, 1, 2 all request bank 0, held, after reset -> acks in order 0, 1, 2 on consecutive cycles; port 0 re-requesting after its rvalid is granted after port 2.
- Port 0 to bank 0 and port 1 to bank 2 in the same cycle -> both acked at T; both rvalids at T+2 with the correct per-bank data.
- Port 0 holds req after ack with no host deassert -> no second ack until the cycle after rvalid[0]; no duplicate bank read.
- Port 2 req=1 with reb=1 -> no ack, no bank activity, proto_err_o=1 next cycle and held.
- rst_n low at T+1 after a grant at T -> all outputs reset immediately; no rvalid at T+2; normal service after release.
